// File: rtl/guess_judge.sv
// Guess judge: debounced submit, unsigned compare to target, hint published only on screenEnd; press->busy 3+DEBOUNCE_CYCLES cycles.
// Presses while busy are dropped, never queued. Define GUESS_LFSR_EN to draw new-round targets from a free-running LFSR.
module guess_judge #(
  parameter int                     GUESS_WIDTH     = 15,
  parameter int                     DEBOUNCE_CYCLES = 1000000,
  parameter int                     MAX_GUESSES     = 15,
  parameter logic [GUESS_WIDTH-1:0] FIXED_TARGET    = GUESS_WIDTH'(1234)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [GUESS_WIDTH-1:0] switch_input,
  input  logic                   playerButton,
  input  logic                   screenEnd,
  output logic [1:0]             hint,
  output logic                   lost,
  output logic [3:0]             guess_count,
  output logic                   busy
);

  localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       MAX_CNT  = 4'(MAX_GUESSES);

  typedef enum logic [2:0] {IDLE, JUDGE, WAIT_FRAME, WON, LOST} state_t;

  state_t                 state, state_nx;
  logic                   btn_s1, btn_s2, btn_acc, press;
  logic [GUESS_WIDTH-1:0] sw_s1, sw_s2;
  logic [CNT_W-1:0]       db_cnt;
  logic [GUESS_WIDTH-1:0] guess_q, target, next_target;
  logic [1:0]             pend;
  logic                   capture, judge, publish, set_lost, new_round;

  // Synchronisers and debounce; press is a one-cycle pulse on the accepted 0->1 flip.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      sw_s1   <= '0;
      sw_s2   <= '0;
      btn_acc <= 1'b0;
      db_cnt  <= '0;
      press   <= 1'b0;
    end else begin
      btn_s1 <= playerButton;
      btn_s2 <= btn_s1;
      sw_s1  <= switch_input;
      sw_s2  <= sw_s1;
      press  <= (btn_s2 != btn_acc) && (db_cnt == CNT_LAST) && btn_s2;
      if (btn_s2 == btn_acc) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_LAST) begin
        btn_acc <= btn_s2;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

`ifdef GUESS_LFSR_EN
  logic [15:0] lfsr;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1, free-running so round targets vary with press timing.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign next_target = lfsr[GUESS_WIDTH-1:0];
`else
  assign next_target = FIXED_TARGET;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    capture   = 1'b0;
    judge     = 1'b0;
    publish   = 1'b0;
    set_lost  = 1'b0;
    new_round = 1'b0;
    case (state)
      IDLE: begin
        if (press) begin
          capture  = 1'b1;
          state_nx = JUDGE;
        end
      end
      JUDGE: begin
        judge    = 1'b1;
        state_nx = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (screenEnd) begin
          publish = 1'b1;
          if (pend == 2'b11) begin
            state_nx = WON;
          end else if (guess_count == MAX_CNT) begin
            set_lost = 1'b1;
            state_nx = LOST;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      WON, LOST: begin
        if (press) begin
          new_round = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      guess_q     <= '0;
      pend        <= 2'b00;
      hint        <= 2'b00;
      lost        <= 1'b0;
      guess_count <= 4'd0;
      target      <= FIXED_TARGET;
    end else begin
      if (capture) begin
        guess_q <= sw_s2;
      end
      if (judge) begin
        if (guess_q == target) begin
          pend <= 2'b11;
        end else if (target > guess_q) begin
          pend <= 2'b01;
        end else begin
          pend <= 2'b10;
        end
        guess_count <= (guess_count == 4'd15) ? 4'd15 : guess_count + 4'd1;
      end
      if (publish) begin
        hint <= pend;
      end
      if (set_lost) begin
        lost <= 1'b1;
      end
      if (new_round) begin
        hint        <= 2'b00;
        lost        <= 1'b0;
        guess_count <= 4'd0;
        target      <= next_target;
      end
    end
  end

  assign busy = (state == JUDGE) || (state == WAIT_FRAME);

endmodule

// File: tb/tb_guess_judge.sv
// Randomised scoreboard bench for guess_judge; a monitor checks every published hint against a round-level game model.
module tb_guess_judge;

  localparam int             GW   = 15;
  localparam int             DB   = 4;
  localparam int             MAXG = 3;
  localparam logic [GW-1:0]  FT   = 15'd1234;

  typedef struct packed {
    logic [1:0] hint;
    logic       lost;
    logic [3:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [GW-1:0] switch_input = '0;
  logic          playerButton = 1'b0;
  logic          screenEnd = 1'b0;
  logic [1:0]    hint_o;
  logic          lost;
  logic [3:0]    guess_count;
  logic          busy;

  int            checks = 0;
  int            errors = 0;
  exp_t          sb[$];
  bit            mon_skip = 1'b0;

  logic [GW-1:0] m_target;
  int            m_count;
  bit            m_over;

  guess_judge #(
    .GUESS_WIDTH    (GW),
    .DEBOUNCE_CYCLES(DB),
    .MAX_GUESSES    (MAXG),
    .FIXED_TARGET   (FT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .switch_input(switch_input),
    .playerButton(playerButton),
    .screenEnd   (screenEnd),
    .hint        (hint_o),
    .lost        (lost),
    .guess_count (guess_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

`ifdef GUESS_LFSR_EN
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end
`endif

  // Frame pulse: one cycle in every 50, changed just after the rising edge.
  initial begin
    int c = 0;
    forever begin
      @(posedge clk);
      #1;
      c = (c == 49) ? 0 : c + 1;
      screenEnd = (c == 0);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: every falling busy outside reset is a publish and must match the oldest expectation.
  initial begin
    bit   bp = 1'b0;
    bit   sq = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_skip || reset) begin
        bp = 1'b0;
      end else begin
        if (bp && !busy) begin
          check("publish_on_frame", int'(sq), 1);
          if (sb.size() == 0) begin
            fail("unexpected_publish");
          end else begin
            e = sb.pop_front();
            check("hint", int'(hint_o), int'(e.hint));
            check("lost", int'(lost), int'(e.lost));
            check("guess_count", int'(guess_count), int'(e.cnt));
          end
        end
        bp = busy;
      end
      sq = screenEnd;
    end
  end

  task automatic wait_frame();
    int n = 0;
    while (screenEnd !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) fail("frame_timeout");
  endtask

  task automatic wait_publish();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      fail("publish_timeout");
      sb.delete();
    end
    repeat (8) @(negedge clk);
  endtask

  // Returns at the negedge right after the edge that takes the press; snap is the LFSR seen by that edge.
  task automatic do_press(input bit bounce, output logic [15:0] snap);
    wait_frame();
    @(negedge clk);
    if (bounce) begin
      repeat (3) begin
        playerButton = 1'b1;
        repeat (3) @(negedge clk);
        playerButton = 1'b0;
        repeat (3) @(negedge clk);
      end
    end
    playerButton = 1'b1;
    repeat (2 + DB) @(negedge clk);
    check("busy_before_press", int'(busy), 0);
`ifdef GUESS_LFSR_EN
    snap = m_lfsr;
`else
    snap = 16'h0000;
`endif
    @(negedge clk);
  endtask

  task automatic guess(input logic [GW-1:0] v, input bit bounce = 1'b0, input bit dbl = 1'b0);
    logic [15:0] snap;
    exp_t        e;
    switch_input = v;
    do_press(bounce, snap);
    if (m_over) begin
      m_over  = 1'b0;
      m_count = 0;
`ifdef GUESS_LFSR_EN
      m_target = snap[GW-1:0];
`else
      m_target = FT;
`endif
      check("new_round_hint", int'(hint_o), 0);
      check("new_round_lost", int'(lost), 0);
      check("new_round_count", int'(guess_count), 0);
      check("new_round_busy", int'(busy), 0);
      playerButton = 1'b0;
      repeat (10) @(negedge clk);
    end else begin
      m_count = (m_count == 15) ? 15 : m_count + 1;
      e.hint  = (v == m_target) ? 2'b11 : (m_target > v) ? 2'b01 : 2'b10;
      e.lost  = (e.hint != 2'b11) && (m_count == MAXG);
      e.cnt   = 4'(m_count);
      m_over  = (e.hint == 2'b11) || e.lost;
      sb.push_back(e);
      check("busy_rise", int'(busy), 1);
      playerButton = 1'b0;
      if (dbl) begin
        repeat (8) @(negedge clk);
        playerButton = 1'b1;
        repeat (8) @(negedge clk);
        playerButton = 1'b0;
      end
      wait_publish();
      if (dbl) begin
        repeat (20) @(negedge clk);
        check("busy_press_dropped", int'(guess_count), m_count);
      end
    end
  endtask

  initial begin
    logic [GW-1:0] v;
    logic [15:0]   snap;
    int            r;
    m_target = FT;
    m_count  = 0;
    m_over   = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_hint", int'(hint_o), 0);
    check("reset_lost", int'(lost), 0);
    check("reset_count", int'(guess_count), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    guess(15'd1000);
    guess(15'd2000);
    guess(15'd1234);
    guess(15'd0);
    guess(m_target);
    guess(15'd0);
    guess(15'd1);
    guess(15'd2);
    guess(15'd3);
    guess(15'd0);
    if (m_over) guess(15'd0);
    guess(15'd1500, 1'b1, 1'b0);
    if (m_over) guess(15'd0);
    guess(15'd1000, 1'b0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       v = m_target;
        1:       v = m_target + 15'd1;
        2:       v = m_target - 15'd1;
        default: v = GW'($urandom);
      endcase
      guess(v);
    end

    // Reset while a judged result waits for its frame.
    if (m_over) guess(15'd0);
    if (m_count == MAXG - 1 || m_target == 15'd1000) begin
      guess(15'd0);
      if (m_over) guess(15'd0);
    end
    guess(m_target == 15'd1000 ? 15'd999 : 15'd1000);
    if (m_over) guess(15'd0);
    switch_input = 15'd2000;
    do_press(1'b0, snap);
    check("busy_before_reset", int'(busy), 1);
    playerButton = 1'b0;
    repeat (5) @(negedge clk);
    mon_skip = 1'b1;
    reset    = 1'b1;
    @(negedge clk);
    check("midreset_hint", int'(hint_o), 0);
    check("midreset_lost", int'(lost), 0);
    check("midreset_count", int'(guess_count), 0);
    check("midreset_busy", int'(busy), 0);
    reset = 1'b0;
    sb.delete();
    m_count  = 0;
    m_target = FT;
    m_over   = 1'b0;
    repeat (3) @(negedge clk);
    mon_skip = 1'b0;
    repeat (60) @(negedge clk);
    guess(15'd1234);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
